// File: rtl/fp_div_seq.sv
// Iterative binary32 divider: one restoring-division step per cycle on the
// 24-bit significands, with a start/busy/done handshake and IEEE special cases.
module fp_div_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int QBITS      = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  div_by_zero,
  output logic                  invalid
);

  localparam int                CNT_W    = $clog2(QBITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(QBITS - 1);
  localparam logic [31:0]       QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_NORM,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [31:0]              r_a;
  logic [31:0]              r_b;
  logic                     r_sign;
  logic signed [9:0]        r_exp;
  logic [QBITS-1:0]         r_rem;
  logic [QBITS-1:0]         r_div;
  logic [QBITS-1:0]         r_quot;
  logic [CNT_W-1:0]         r_cnt;
  logic [31:0]              r_q;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_ovf;
  logic                     r_udf;
  logic                     r_dbz;
  logic                     r_inv;

  function automatic logic f_is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic f_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Truncating normalisation: the quotient lies in (0.5, 2), so at most one
  // position of left shift is ever needed.
  function automatic logic [22:0] f_trunc_frac(input logic [24:0] quot);
    return quot[24] ? quot[23:1] : quot[22:0];
  endfunction

  function automatic logic signed [9:0] f_norm_exp(input logic signed [9:0] e,
                                                   input logic            msb);
    return msb ? (e + 10'sd127) : (e + 10'sd126);
  endfunction

  logic                     w_sign;
  logic                     w_a_zero;
  logic                     w_b_zero;
  logic                     w_a_inf;
  logic                     w_b_inf;
  logic                     w_a_nan;
  logic                     w_b_nan;
  logic signed [9:0]        w_exp_diff;
  logic                     w_ge;
  logic [QBITS-1:0]         w_diff;
  logic [QBITS-1:0]         w_sel;
  logic [QBITS-1:0]         w_rem_nx;
  logic signed [9:0]        w_e_norm;
  logic [22:0]              w_frac;

  always_comb begin
    w_sign     = r_a[31] ^ r_b[31];
    w_a_zero   = f_is_zero(r_a);
    w_b_zero   = f_is_zero(r_b);
    w_a_inf    = f_is_inf(r_a);
    w_b_inf    = f_is_inf(r_b);
    w_a_nan    = f_is_nan(r_a);
    w_b_nan    = f_is_nan(r_b);
    w_exp_diff = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]});
    w_ge       = r_rem >= r_div;
    w_diff     = r_rem - r_div;
    w_sel      = w_ge ? w_diff : r_rem;
    w_rem_nx   = w_sel << 1;
    w_e_norm   = f_norm_exp(r_exp, r_quot[24]);
    w_frac     = f_trunc_frac(r_quot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quot  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_dbz   <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // busy stays up through the done cycle, so it falls with done
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        S_PREP: begin
          r_sign <= w_sign;
          r_q    <= '0;
          r_ovf  <= 1'b0;
          r_udf  <= 1'b0;
          r_dbz  <= 1'b0;
          r_inv  <= 1'b0;
          if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            r_q     <= QNAN;
            r_inv   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_b_zero) begin
            r_q     <= {w_sign, 8'hFF, 23'd0};
            r_dbz   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_a_inf) begin
            r_q     <= {w_sign, 8'hFF, 23'd0};
            r_state <= S_DONE;
          end else if (w_a_zero || w_b_inf) begin
            r_q     <= {w_sign, 31'd0};
            r_state <= S_DONE;
          end else begin
            r_rem   <= {2'b01, r_a[22:0]};
            r_div   <= {2'b01, r_b[22:0]};
            r_quot  <= '0;
            r_exp   <= w_exp_diff;
            r_cnt   <= CNT_LAST;
            r_state <= S_DIV;
          end
        end

        S_DIV: begin
          r_rem  <= w_rem_nx;
          r_quot <= {r_quot[QBITS-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_NORM;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end

        S_NORM: begin
          if (w_e_norm >= 10'sd255) begin
            r_q   <= {r_sign, 8'hFF, 23'd0};
            r_ovf <= 1'b1;
          end else if (w_e_norm <= 10'sd0) begin
            r_q   <= {r_sign, 31'd0};
            r_udf <= 1'b1;
          end else begin
            r_q   <= {r_sign, w_e_norm[7:0], w_frac};
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign q           = r_q;
  assign overflow    = r_ovf;
  assign underflow   = r_udf;
  assign div_by_zero = r_dbz;
  assign invalid     = r_inv;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq: hand-computed quotients, flags,
// latency, ignored mid-operation starts and asynchronous abort.
module tb_fp_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  int n_vec = 0;
  int n_err = 0;

  fp_div_seq #(.DATA_WIDTH(32), .QBITS(25)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .q          (q),
    .overflow   (overflow),
    .underflow  (underflow),
    .div_by_zero(div_by_zero),
    .invalid    (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, overflow, underflow, div_by_zero, invalid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input int exp_lat, input logic [31:0] exp_q, input logic [31:0] exp_f);
    int lat;
    a = ta;
    b = tb_;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " q"}, q, exp_q);
    chk({tag, " flags"}, flags(), exp_f);
    chk({tag, " busy@done"}, {31'd0, busy}, 32'd1);
    tick();
    chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
    chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("reset q", q, 32'h0);
    chk("reset flags", flags(), 32'h0);
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // flag order: {overflow, underflow, div_by_zero, invalid}
    run_op("6/2",      32'h40C00000, 32'h40000000, 28, 32'h40400000, 32'h0);
    run_op("1/3",      32'h3F800000, 32'h40400000, 28, 32'h3EAAAAAA, 32'h0);
    run_op("min/2",    32'h00800000, 32'h40000000, 28, 32'h00000000, 32'h4);
    run_op("-1/0",     32'hBF800000, 32'h00000000, 2,  32'hFF800000, 32'h2);
    run_op("inf/inf",  32'h7F800000, 32'h7F800000, 2,  32'h7FC00000, 32'h1);
    run_op("big/0.25", 32'h7F000000, 32'h3E800000, 28, 32'h7F800000, 32'h8);
    run_op("0/-2",     32'h00000000, 32'hC0000000, 2,  32'h80000000, 32'h0);
    run_op("nan/1",    32'h7FC00001, 32'h3F800000, 2,  32'h7FC00000, 32'h1);
    run_op("-3/1.5",   32'hC0400000, 32'h3FC00000, 28, 32'hC0000000, 32'h0);

    // A start pulse with new operands mid-division must be ignored.
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (10) begin
      tick();
      lat++;
    end
    chk("mid busy", {31'd0, busy}, 32'd1);
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk("ignore latency", 32'(lat), 32'd28);
    chk("ignore q", q, 32'h40400000);
    tick();

    // Abort in the 10th DIV cycle: everything clears and no done follows.
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("abort q", q, 32'h0);
    chk("abort busy/done", {30'd0, busy, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    chk("abort no done", 32'(done_seen), 32'd0);
    chk("abort idle busy", {31'd0, busy}, 32'd0);

    run_op("6/2 again", 32'h40C00000, 32'h40000000, 28, 32'h40400000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
